// File: rtl/model_tensor_float_adder_scheduler_pkg.sv
// Shared state encoding and constants for the tensor float adder scheduler.
// The timeout default applies only when MODEL_TENSOR_FLOAT_ADDER_SCHEDULER_TIMEOUT_EN is defined.
package model_tensor_float_adder_scheduler_pkg;

    typedef enum logic [2:0] {
        STARTER   = 3'd0,
        CHECK     = 3'd1,
        ROW_START = 3'd2,
        ROW_FEED  = 3'd3,
        ROW_WAIT  = 3'd4,
        ENDER     = 3'd5
    } state_t;

    localparam int unsigned DEFAULT_DATA_SIZE      = 64;
    localparam int unsigned DEFAULT_CONTROL_SIZE   = 64;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

    localparam logic [DEFAULT_CONTROL_SIZE-1:0] ZERO_CONTROL = '0;
    localparam logic [DEFAULT_CONTROL_SIZE-1:0] ONE_CONTROL  = 64'd1;
    localparam logic [DEFAULT_DATA_SIZE-1:0]    ZERO_DATA    = '0;
    localparam logic [DEFAULT_DATA_SIZE-1:0]    ONE_DATA     = 64'd1;

endpackage

// File: rtl/model_tensor_index_counter.sv
// Three-level wrapping I/J/K position counter; K is the fastest index.
// first_j marks the first element of a J-row, first_i the first element of an I-slice.
module model_tensor_index_counter
    import model_tensor_float_adder_scheduler_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_CONTROL_SIZE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             step,
    input  logic [WIDTH-1:0] size_i,
    input  logic [WIDTH-1:0] size_j,
    input  logic [WIDTH-1:0] size_k,
    output logic [WIDTH-1:0] index_i,
    output logic [WIDTH-1:0] index_j,
    output logic [WIDTH-1:0] index_k,
    output logic             first_j,
    output logic             first_i
);

    localparam logic [WIDTH-1:0] CNT_ZERO = WIDTH'(ZERO_CONTROL);
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(ONE_CONTROL);

    logic last_k;
    logic last_j;
    logic last_i;

    assign last_k  = index_k == size_k - CNT_ONE;
    assign last_j  = index_j == size_j - CNT_ONE;
    assign last_i  = index_i == size_i - CNT_ONE;
    assign first_j = index_k == CNT_ZERO;
    assign first_i = first_j && (index_j == CNT_ZERO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_i <= CNT_ZERO;
            index_j <= CNT_ZERO;
            index_k <= CNT_ZERO;
        end else if (clear) begin
            index_i <= CNT_ZERO;
            index_j <= CNT_ZERO;
            index_k <= CNT_ZERO;
        end else if (step) begin
            if (!last_k) begin
                index_k <= index_k + CNT_ONE;
            end else begin
                index_k <= CNT_ZERO;
                if (!last_j) begin
                    index_j <= index_j + CNT_ONE;
                end else begin
                    index_j <= CNT_ZERO;
                    index_i <= last_i ? CNT_ZERO : index_i + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: rtl/model_tensor_float_adder_scheduler.sv
// Walks an I x J x K tensor as I*J vector-adder operations of K elements each.
// Optional ROW_WAIT watchdog: define MODEL_TENSOR_FLOAT_ADDER_SCHEDULER_TIMEOUT_EN.
//
// state     | meaning
// STARTER   | idle, waiting for START
// CHECK     | compare A/B shapes, detect empty tensor
// ROW_START | one-cycle VECTOR_START for the next J-row
// ROW_FEED  | K element enables to the vector adder
// ROW_WAIT  | wait for VECTOR_READY of the current row
// ENDER     | one-cycle READY
module model_tensor_float_adder_scheduler
    import model_tensor_float_adder_scheduler_pkg::*;
#(
    parameter int unsigned DATA_SIZE    = DEFAULT_DATA_SIZE,
    parameter int unsigned CONTROL_SIZE = DEFAULT_CONTROL_SIZE
`ifdef MODEL_TENSOR_FLOAT_ADDER_SCHEDULER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    output logic                    READY,
    output logic                    ERROR,
    input  logic                    OPERATION,
    input  logic [DATA_SIZE-1:0]    SIZE_A_I_IN,
    input  logic [DATA_SIZE-1:0]    SIZE_A_J_IN,
    input  logic [DATA_SIZE-1:0]    SIZE_A_K_IN,
    input  logic [DATA_SIZE-1:0]    SIZE_B_I_IN,
    input  logic [DATA_SIZE-1:0]    SIZE_B_J_IN,
    input  logic [DATA_SIZE-1:0]    SIZE_B_K_IN,
    output logic                    DATA_IN_I_ENABLE,
    output logic                    DATA_IN_J_ENABLE,
    output logic                    DATA_IN_K_ENABLE,
    output logic                    DATA_OUT_I_ENABLE,
    output logic                    DATA_OUT_J_ENABLE,
    output logic                    DATA_OUT_K_ENABLE,
    output logic [CONTROL_SIZE-1:0] INDEX_I,
    output logic [CONTROL_SIZE-1:0] INDEX_J,
    output logic [CONTROL_SIZE-1:0] INDEX_K,
    output logic                    VECTOR_START,
    input  logic                    VECTOR_READY,
    output logic                    VECTOR_OPERATION,
    output logic [DATA_SIZE-1:0]    VECTOR_SIZE,
    output logic                    VECTOR_DATA_IN_ENABLE,
    input  logic                    VECTOR_DATA_OUT_ENABLE
);

    localparam logic [CONTROL_SIZE-1:0] CTRL_ZERO = CONTROL_SIZE'(ZERO_CONTROL);
    localparam logic [DATA_SIZE-1:0]    DAT_ZERO  = DATA_SIZE'(ZERO_DATA);
    localparam logic [DATA_SIZE-1:0]    DAT_ONE   = DATA_SIZE'(ONE_DATA);

    state_t                  state;
    state_t                  state_nxt;
    logic [DATA_SIZE-1:0]    size_i;
    logic [DATA_SIZE-1:0]    size_j;
    logic [DATA_SIZE-1:0]    size_k;
    logic [CONTROL_SIZE-1:0] lim_i;
    logic [CONTROL_SIZE-1:0] lim_j;
    logic [CONTROL_SIZE-1:0] lim_k;
    logic [CONTROL_SIZE-1:0] out_i;
    logic [CONTROL_SIZE-1:0] out_j;
    logic [CONTROL_SIZE-1:0] out_k;
    logic operation;
    logic error;
    logic mismatch;
    logic any_zero;
    logic accept;
    logic feed_step;
    logic out_step;
    logic row_end;
    logic rows_done;
    logic set_error;
    logic timeout;
    logic feed_first_j;
    logic feed_first_i;
    logic out_first_j;
    logic out_first_i;

    assign lim_i     = CONTROL_SIZE'(size_i);
    assign lim_j     = CONTROL_SIZE'(size_j);
    assign lim_k     = CONTROL_SIZE'(size_k);
    assign accept    = (state == STARTER) && START;
    assign feed_step = state == ROW_FEED;
    assign out_step  = VECTOR_DATA_OUT_ENABLE && ((state == ROW_FEED) || (state == ROW_WAIT));
    assign row_end   = INDEX_K == CONTROL_SIZE'(size_k - DAT_ONE);
    assign any_zero  = (size_i == DAT_ZERO) || (size_j == DAT_ZERO) || (size_k == DAT_ZERO);
    // The feed counter only returns to the origin after the last element of the last row.
    assign rows_done = feed_first_i && (INDEX_I == CTRL_ZERO);

    assign ERROR            = error;
    assign VECTOR_OPERATION = operation;
    assign VECTOR_SIZE      = size_k;

    model_tensor_index_counter #(.WIDTH(CONTROL_SIZE)) u_feed_cnt (
        .clk     (CLK),
        .rst_n   (RST),
        .clear   (accept),
        .step    (feed_step),
        .size_i  (lim_i),
        .size_j  (lim_j),
        .size_k  (lim_k),
        .index_i (INDEX_I),
        .index_j (INDEX_J),
        .index_k (INDEX_K),
        .first_j (feed_first_j),
        .first_i (feed_first_i)
    );

    model_tensor_index_counter #(.WIDTH(CONTROL_SIZE)) u_out_cnt (
        .clk     (CLK),
        .rst_n   (RST),
        .clear   (accept),
        .step    (out_step),
        .size_i  (lim_i),
        .size_j  (lim_j),
        .size_k  (lim_k),
        .index_i (out_i),
        .index_j (out_j),
        .index_k (out_k),
        .first_j (out_first_j),
        .first_i (out_first_i)
    );

`ifdef MODEL_TENSOR_FLOAT_ADDER_SCHEDULER_TIMEOUT_EN
    localparam logic [31:0] TIMER_LOAD = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] timer;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            timer <= TIMER_LOAD;
        end else if (state != ROW_WAIT) begin
            timer <= TIMER_LOAD;
        end else if (timer != 32'd0) begin
            timer <= timer - 32'd1;
        end
    end

    assign timeout = (state == ROW_WAIT) && (timer == 32'd0);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= STARTER;
            size_i    <= DAT_ZERO;
            size_j    <= DAT_ZERO;
            size_k    <= DAT_ZERO;
            operation <= 1'b0;
            mismatch  <= 1'b0;
            error     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                size_i    <= SIZE_A_I_IN;
                size_j    <= SIZE_A_J_IN;
                size_k    <= SIZE_A_K_IN;
                operation <= OPERATION;
                mismatch  <= (SIZE_A_I_IN != SIZE_B_I_IN) || (SIZE_A_J_IN != SIZE_B_J_IN)
                             || (SIZE_A_K_IN != SIZE_B_K_IN);
                error     <= 1'b0;
            end else if (set_error) begin
                error <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt             = state;
        set_error             = 1'b0;
        READY                 = 1'b0;
        VECTOR_START          = 1'b0;
        VECTOR_DATA_IN_ENABLE = 1'b0;
        DATA_IN_K_ENABLE      = 1'b0;
        DATA_IN_J_ENABLE      = 1'b0;
        DATA_IN_I_ENABLE      = 1'b0;
        DATA_OUT_K_ENABLE     = out_step;
        DATA_OUT_J_ENABLE     = out_step && out_first_j;
        DATA_OUT_I_ENABLE     = out_step && out_first_i;
        unique case (state)
            STARTER: begin
                if (START) state_nxt = CHECK;
            end
            CHECK: begin
                if (mismatch) begin
                    set_error = 1'b1;
                    state_nxt = ENDER;
                end else if (any_zero) begin
                    state_nxt = ENDER;
                end else begin
                    state_nxt = ROW_START;
                end
            end
            ROW_START: begin
                VECTOR_START = 1'b1;
                state_nxt    = ROW_FEED;
            end
            ROW_FEED: begin
                VECTOR_DATA_IN_ENABLE = 1'b1;
                DATA_IN_K_ENABLE      = 1'b1;
                DATA_IN_J_ENABLE      = feed_first_j;
                DATA_IN_I_ENABLE      = feed_first_i;
                if (row_end) state_nxt = ROW_WAIT;
            end
            ROW_WAIT: begin
                if (VECTOR_READY) begin
                    state_nxt = rows_done ? ENDER : ROW_START;
                end else if (timeout) begin
                    set_error = 1'b1;
                    state_nxt = ENDER;
                end
            end
            ENDER: begin
                READY     = 1'b1;
                state_nxt = STARTER;
            end
            default: state_nxt = STARTER;
        endcase
    end

endmodule

// File: doc/model_tensor_float_adder_scheduler.md
# model_tensor_float_adder_scheduler

Sequencer placed between the tensor float adder level and a `model_vector_float_adder` instance. It validates the A/B tensor shapes and walks the I×J×K index space. Each J-row of K elements is issued to the vector adder as one vector operation: start the vector, stream K element enables, wait for vector READY. The block regenerates tensor-level I/J/K input and output strobes and indices for address generation. The datapath (DATA_A_IN, DATA_B_IN, DATA_OUT) bypasses this block.

## Interface
- DATA_SIZE, 64, width of size fields
- CONTROL_SIZE, 64, width of index counters
- TIMEOUT_CYCLES, 1024, watchdog limit per row (used only with the macro defined)

- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- START  in  1  begin tensor operation (sampled in STARTER only)
- READY  out  1  one-cycle done pulse
- ERROR  out  1  held from READY until next accepted START
- OPERATION  in  1  0 add, 1 subtract; latched at START
- SIZE_A_I_IN / SIZE_A_J_IN / SIZE_A_K_IN  in  DATA_SIZE each  A shape
- SIZE_B_I_IN / SIZE_B_J_IN / SIZE_B_K_IN  in  DATA_SIZE each  B shape
- DATA_IN_I_ENABLE / DATA_IN_J_ENABLE / DATA_IN_K_ENABLE  out  1 each  input position strobes
- DATA_OUT_I_ENABLE / DATA_OUT_J_ENABLE / DATA_OUT_K_ENABLE  out  1 each  output position strobes
- INDEX_I / INDEX_J / INDEX_K  out  CONTROL_SIZE each  current feed index
- VECTOR_START  out  1  vector adder START
- VECTOR_READY  in  1  vector adder READY
- VECTOR_OPERATION  out  1  latched OPERATION
- VECTOR_SIZE  out  DATA_SIZE  equals latched K
- VECTOR_DATA_IN_ENABLE  out  1  drives both vector A/B enables
- VECTOR_DATA_OUT_ENABLE  in  1  vector output element valid

## Operation
- States: STARTER, CHECK, ROW_START, ROW_FEED, ROW_WAIT, ENDER.
- STARTER: START=1 latches the A sizes as I/J/K and latches OPERATION, then goes to CHECK. While not in STARTER, START is ignored.
- CHECK:
  - A shape ≠ B shape (any dimension): ERROR=1, go to ENDER.
  - Any dimension 0: ERROR=0, go to ENDER with no vector activity.
  - Otherwise: go to ROW_START.
- ROW_START: VECTOR_START=1 for exactly one cycle, then go to ROW_FEED.
- ROW_FEED: K consecutive cycles with VECTOR_DATA_IN_ENABLE=1 and DATA_IN_K_ENABLE=1.
  - DATA_IN_J_ENABLE=1 with INDEX_K=0.
  - DATA_IN_I_ENABLE=1 with INDEX_J=0 and INDEX_K=0.
  - After the element with INDEX_K=K-1, go to ROW_WAIT.
- Feed index wrap: K-1→0 increments J; J-1→0 increments I. Indices are valid during each feed cycle.
- ROW_WAIT: on VECTOR_READY, go to ROW_START if rows remain, else ENDER.
- Output counters (separate I/J/K): advance on each VECTOR_DATA_OUT_ENABLE.
  - DATA_OUT_K_ENABLE mirrors VECTOR_DATA_OUT_ENABLE.
  - J/I strobes follow the same first-element rule as the input side.
- ENDER: READY=1 for one cycle, then go to STARTER.
- VECTOR_DATA_OUT_ENABLE outside ROW_FEED/ROW_WAIT is ignored.

## Timing
- Reset values: all outputs 0. Indices 0, state STARTER, ERROR 0.
- Reset mid-operation aborts immediately. VECTOR_START/VECTOR_DATA_IN_ENABLE drop asynchronously.
- START accepted at cycle 0: CHECK at cycle 1, VECTOR_START at cycle 2, feed cycles 3..K+2.
- Row-to-row gap: VECTOR_READY cycle + 1 = next VECTOR_START.
- READY is asserted the cycle after the final VECTOR_READY.
- Mismatch or zero size: READY at cycle 2.
- START held high through READY does not retrigger until the cycle after READY.

## Configuration
- MODEL_TENSOR_FLOAT_ADDER_SCHEDULER_TIMEOUT_EN defined:
  - A counter runs in ROW_WAIT.
  - Reaching TIMEOUT_CYCLES without VECTOR_READY sets ERROR=1 and goes to ENDER.
- Undefined: ROW_WAIT waits indefinitely and TIMEOUT_CYCLES is unused.

## Structure
- Package model_tensor_float_adder_scheduler_pkg holds:
  - state encoding (6 states, 3-bit);
  - ZERO/ONE control and data constants;
  - default TIMEOUT_CYCLES.
- Sub-module model_tensor_index_counter: 3-level wrapping I/J/K counter with first/last flags. It is instantiated twice, once for feed and once for output.

## Test plan
- A=B=2×3×4, OPERATION=1 → 6 VECTOR_START pulses, 24 feed enables, VECTOR_SIZE=4, VECTOR_OPERATION=1, READY one cycle after 6th VECTOR_READY, ERROR=0.
- A=2×3×4, B=2×3×5 → READY at cycle 2, ERROR=1, no VECTOR_START.
- A=B=1×1×0 → READY at cycle 2, ERROR=0, no vector activity.
- 1×2×3, 3 VECTOR_DATA_OUT_ENABLE per row → DATA_OUT_I_ENABLE once, DATA_OUT_J_ENABLE twice, DATA_OUT_K_ENABLE six times.
- RST low during second row feed → all outputs 0 same cycle; new START runs a full correct sequence.
- With macro defined, TIMEOUT_CYCLES=8, VECTOR_READY never asserted → READY with ERROR=1 at 8 cycles after entering ROW_WAIT.
